// File: rtl/hub75_pkg.sv
// hub75_pkg: shared encodings, field offsets
// and on-time helper for the HUB75 scan core.
package hub75_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT,
    BLK_PRE,
    LAT,
    BLK_POST
  } scan_state_t;

  localparam int COLS_DEF    = 64;
  localparam int ROWS_DEF    = 32;
  localparam int BPC_DEF     = 4;
  localparam int BASE_ON_DEF = 8;

  localparam int ADDR_W = $clog2(ROWS_DEF);
  localparam int COL_W  = $clog2(COLS_DEF);

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  localparam int HALF_TOP = 0;
  localparam int HALF_BOT = 1;

  // LSB of one colour channel inside rd_data
  function automatic int chan_lsb(
    input int bpc,
    input int half,
    input int ch
  );
    return (half * 3 + ch) * bpc;
  endfunction

  // display cycles for bit-plane p
  function automatic int unsigned on_time(
    input int unsigned base,
    input int unsigned p
  );
    return base << p;
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// hub75_bcm_timer: loadable down-counter whose
// busy flag gates the panel output enable.
module hub75_bcm_timer #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy,
  output logic         busy_nxt
);

  logic [W-1:0] count;
  logic [W-1:0] count_d;

  // load wins, otherwise count down to zero
  always_comb begin
    count_d = count;
    if (load)
      count_d = load_val;
    else if (count != '0)
      count_d = count - 1'b1;
  end

  // counter register
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn)
      count <= '0;
    else
      count <= count_d;
  end

  assign busy     = (count != '0);
  assign busy_nxt = (count_d != '0);

endmodule

// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: HUB75 row/bit-plane scan
// sequencer with BCM display timing.
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int COLS    = COLS_DEF,
  parameter int ROWS    = ROWS_DEF,
  parameter int BPC     = BPC_DEF,
  parameter int BASE_ON = BASE_ON_DEF
) (
  input  logic CLK,
  input  logic resetn,
  input  logic en,
  output logic [$clog2(ROWS)+$clog2(COLS)-1:0]
               rd_addr,
  input  logic [6*BPC-1:0] rd_data,
  output logic [2:0] RGB0,
  output logic [2:0] RGB1,
  output logic [$clog2(ROWS)-1:0] ADDR,
  output logic BLANK,
  output logic LATCH,
  output logic SCLK,
  output logic frame_start
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int PW = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int DW = 6 * BPC;
  localparam int SW = $clog2(2 * COLS + 2);
  localparam int TW =
    $clog2(BASE_ON << (BPC - 1)) + 1;

  localparam logic [SW-1:0] SHIFT_LAST =
    SW'(2 * COLS + 1);
  localparam logic [SW-1:0] DATA_END =
    SW'(2 * COLS);
  localparam logic [SW-1:0] CNT_TWO = SW'(2);

  localparam logic [RW-1:0] ROW_LAST =
    RW'(ROWS - 1);
  localparam logic [PW-1:0] PLANE_LAST =
    PW'(BPC - 1);

  localparam int R0 = chan_lsb(BPC, HALF_TOP, CH_R);
  localparam int G0 = chan_lsb(BPC, HALF_TOP, CH_G);
  localparam int B0 = chan_lsb(BPC, HALF_TOP, CH_B);
  localparam int R1 = chan_lsb(BPC, HALF_BOT, CH_R);
  localparam int G1 = chan_lsb(BPC, HALF_BOT, CH_G);
  localparam int B1 = chan_lsb(BPC, HALF_BOT, CH_B);

  scan_state_t state_q, state_d;

  logic [SW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic [PW-1:0] plane_q, plane_d;

  logic          busy, busy_nxt;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;

  logic [RW+CW-1:0] rd_addr_d;
  logic [2:0]       rgb0_d, rgb1_d;
  logic [RW-1:0]    addr_d;
  logic             blank_d, latch_d;
  logic             sclk_d, frame_d;
  logic [DW-1:0]    px_sh;

  hub75_bcm_timer #(
    .W (TW)
  ) u_timer (
    .CLK      (CLK),
    .resetn   (resetn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .busy     (busy),
    .busy_nxt (busy_nxt)
  );

  // on-time of the plane just latched
  assign tmr_load = (state_q == BLK_POST) && en;
  assign tmr_val  = TW'(on_time(BASE_ON, plane_q));

  // FSM state register
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (en) state_d = SHIFT;
      SHIFT:
        if (cnt_q == SHIFT_LAST)
          state_d = busy ? WAIT : BLK_PRE;
      WAIT:
        if (!busy) state_d = BLK_PRE;
      BLK_PRE:  state_d = LAT;
      LAT:      state_d = BLK_POST;
      BLK_POST: state_d = en ? SHIFT : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // shift counter and row/plane target
  always_comb begin
    cnt_d   = '0;
    row_d   = row_q;
    plane_d = plane_q;
    if (state_q == SHIFT && cnt_q != SHIFT_LAST)
      cnt_d = cnt_q + 1'b1;
    if (state_q == IDLE) begin
      row_d   = '0;
      plane_d = '0;
    end else if (state_q == BLK_POST) begin
      if (!en) begin
        row_d   = '0;
        plane_d = '0;
      end else if (plane_q == PLANE_LAST) begin
        plane_d = '0;
        row_d   = (row_q == ROW_LAST) ?
                  '0 : row_q + 1'b1;
      end else begin
        plane_d = plane_q + 1'b1;
      end
    end
  end

  // sequencer registers
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      row_q   <= '0;
      plane_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      plane_q <= plane_d;
    end
  end

  // FSM output logic: next values of the pins
  always_comb begin
    rd_addr_d = rd_addr;
    rgb0_d    = RGB0;
    rgb1_d    = RGB1;
    addr_d    = ADDR;
    px_sh     = rd_data >> plane_q;
    if (state_d == SHIFT && cnt_d < DATA_END)
      rd_addr_d = {row_d, cnt_d[CW:1]};
    if (state_q == SHIFT && cnt_q[0] &&
        cnt_q < DATA_END) begin
      rgb0_d = {px_sh[B0], px_sh[G0], px_sh[R0]};
      rgb1_d = {px_sh[B1], px_sh[G1], px_sh[R1]};
    end
    sclk_d = (state_q == SHIFT) && !cnt_q[0] &&
             (cnt_q >= CNT_TWO) &&
             (cnt_q <= DATA_END);
    latch_d = (state_d == LAT);
    frame_d = (state_d == LAT) &&
              (row_q == '0) && (plane_q == '0);
    if (state_d == LAT)
      addr_d = row_q;
    blank_d = !(busy_nxt &&
                (state_d == SHIFT ||
                 state_d == WAIT));
  end

  // registered panel and framebuffer outputs
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      rd_addr     <= '0;
      RGB0        <= '0;
      RGB1        <= '0;
      ADDR        <= '0;
      BLANK       <= 1'b1;
      LATCH       <= 1'b0;
      SCLK        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      rd_addr     <= rd_addr_d;
      RGB0        <= rgb0_d;
      RGB1        <= rgb1_d;
      ADDR        <= addr_d;
      BLANK       <= blank_d;
      LATCH       <= latch_d;
      SCLK        <= sclk_d;
      frame_start <= frame_d;
    end
  end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// tb_hub75_scan_ctrl: directed bench for the
// HUB75 scan sequencer (4 cols, 2 planes).
module tb_hub75_scan_ctrl;

  localparam int COLS    = 4;
  localparam int ROWS    = 32;
  localparam int BPC     = 2;
  localparam int BASE_ON = 16;
  localparam int SHLEN   = 2 * COLS + 2;

  logic        CLK = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic [6:0]  rd_addr;
  logic [11:0] rd_data = '0;
  logic [2:0]  RGB0, RGB1;
  logic [4:0]  ADDR;
  logic        BLANK, LATCH, SCLK, frame_start;

  int checks = 0;
  int errors = 0;
  int lat_row = 0;
  int lat_plane = 0;

  hub75_scan_ctrl #(
    .COLS    (COLS),
    .ROWS    (ROWS),
    .BPC     (BPC),
    .BASE_ON (BASE_ON)
  ) dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .en          (en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .RGB0        (RGB0),
    .RGB1        (RGB1),
    .ADDR        (ADDR),
    .BLANK       (BLANK),
    .LATCH       (LATCH),
    .SCLK        (SCLK),
    .frame_start (frame_start)
  );

  always #5 CLK = ~CLK;

  // framebuffer model: 1-cycle latency,
  // data = low 12 bits of address replicated
  always @(posedge CLK)
    rd_data <= {rd_addr[4:0], rd_addr};

  function automatic logic [2:0] exp_rgb(
    input int row, input int col,
    input int plane, input int half
  );
    logic [6:0]  a;
    logic [11:0] d;
    a = {row[4:0], col[1:0]};
    d = {a[4:0], a};
    d = d >> (half * 6 + plane);
    return {d[4], d[2], d[0]};
  endfunction

  task automatic step();
    @(negedge CLK);
  endtask

  // Follow one plane from SHIFT cycle 0 through
  // its latch and BLK_POST, checking every pin.
  task automatic follow_plane(
    input int on_cyc, input int row_lat,
    input bit fs_exp, input int sh_row,
    input int sh_plane, input int prev_addr,
    input int en_off_at, input int en_on_at,
    input int abort_at
  );
    int lat_at;
    bit sclk_e, lat_e, fs_e, blank_e;
    logic [4:0] addr_e;
    logic [6:0] ra_e;
    logic [2:0] c0, c1;
    lat_at = (on_cyc >= SHLEN) ?
             on_cyc + 2 : SHLEN + 1;
    for (int n = 0; n <= lat_at; n++) begin
      sclk_e = (n < SHLEN) && (n >= 3) &&
               (n % 2 == 1);
      checks++;
      if (SCLK !== sclk_e) begin
        errors++;
        $display("FAIL sclk r%0d p%0d n=%0d: got %b want %b",
                 sh_row, sh_plane, n, SCLK, sclk_e);
      end
      if (sclk_e) begin
        c0 = exp_rgb(sh_row, (n - 3) / 2, sh_plane, 0);
        c1 = exp_rgb(sh_row, (n - 3) / 2, sh_plane, 1);
        checks++;
        if (RGB0 !== c0 || RGB1 !== c1) begin
          errors++;
          $display("FAIL rgb r%0d p%0d n=%0d: got %h/%h want %h/%h",
                   sh_row, sh_plane, n, RGB0, RGB1, c0, c1);
        end
      end
      if (n % 2 == 0 && n < 2 * COLS) begin
        ra_e = {sh_row[4:0], 2'(n / 2)};
        checks++;
        if (rd_addr !== ra_e) begin
          errors++;
          $display("FAIL rd_addr n=%0d: got %h want %h",
                   n, rd_addr, ra_e);
        end
      end
      blank_e = (n >= on_cyc);
      checks++;
      if (BLANK !== blank_e) begin
        errors++;
        $display("FAIL blank r%0d p%0d n=%0d: got %b want %b",
                 sh_row, sh_plane, n, BLANK, blank_e);
      end
      lat_e = (n == lat_at);
      fs_e  = lat_e && fs_exp;
      checks++;
      if (LATCH !== lat_e || frame_start !== fs_e) begin
        errors++;
        $display("FAIL latch/fs n=%0d: got %b/%b want %b/%b",
                 n, LATCH, frame_start, lat_e, fs_e);
      end
      addr_e = lat_e ? row_lat[4:0] : prev_addr[4:0];
      checks++;
      if (ADDR !== addr_e) begin
        errors++;
        $display("FAIL addr n=%0d: got %0d want %0d",
                 n, ADDR, addr_e);
      end
      if (n == abort_at) return;
      if (n == en_off_at) en = 1'b0;
      if (n == en_on_at) en = 1'b1;
      step();
    end
    checks++;
    if (BLANK !== 1'b1 || LATCH !== 1'b0 ||
        SCLK !== 1'b0 || frame_start !== 1'b0 ||
        ADDR !== row_lat[4:0]) begin
      errors++;
      $display("FAIL blk_post: got b%b l%b s%b f%b a%0d want b1 l0 s0 f0 a%0d",
               BLANK, LATCH, SCLK, frame_start, ADDR, row_lat);
    end
    step();
  endtask

  task automatic advance(
    input int en_off_at, input int en_on_at,
    input int abort_at
  );
    int tr, tp;
    tp = (lat_plane == BPC - 1) ? 0 : lat_plane + 1;
    tr = (lat_plane == BPC - 1) ?
         (lat_row + 1) % ROWS : lat_row;
    follow_plane(BASE_ON << lat_plane, tr,
                 (tr == 0 && tp == 0), tr, tp,
                 lat_row, en_off_at, en_on_at, abort_at);
    lat_row   = tr;
    lat_plane = tp;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    en     = 1'b0;
    repeat (3) step();
    checks++;
    if (BLANK !== 1'b1 || LATCH !== 1'b0 ||
        SCLK !== 1'b0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got b%b l%b s%b f%b want b1 l0 s0 f0",
               BLANK, LATCH, SCLK, frame_start);
    end
    checks++;
    if (RGB0 !== 3'd0 || RGB1 !== 3'd0 ||
        ADDR !== 5'd0 || rd_addr !== 7'd0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %0d %h want 0",
               RGB0, RGB1, ADDR, rd_addr);
    end
    resetn = 1'b1;
    repeat (4) step();
    checks++;
    if (BLANK !== 1'b1 || SCLK !== 1'b0 ||
        LATCH !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got b%b s%b l%b want b1 s0 l0",
               BLANK, SCLK, LATCH);
    end
  endtask

  task automatic test_shift();
    en = 1'b1;
    step();
    follow_plane(0, 0, 1'b1, 0, 0, 0, -1, -1, -1);
    lat_row   = 0;
    lat_plane = 0;
  endtask

  task automatic test_bcm();
    advance(-1, -1, -1);
    advance(-1, -1, -1);
  endtask

  task automatic test_en_toggle();
    advance(2, 5, -1);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 70; i++) begin
      advance(-1, -1, -1);
      if (lat_row == 0 && lat_plane == 0) break;
    end
    checks++;
    if (lat_row != 0 || lat_plane != 0) begin
      errors++;
      $display("FAIL wrap: got r%0d p%0d want r0 p0",
               lat_row, lat_plane);
    end
    advance(-1, -1, -1);
  endtask

  task automatic test_en_off();
    while (!(lat_row == 5 && lat_plane == 0))
      advance(-1, -1, -1);
    advance(4, -1, -1);
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (BLANK !== 1'b1 || LATCH !== 1'b0 ||
          SCLK !== 1'b0 || ADDR !== 5'd5 ||
          frame_start !== 1'b0) begin
        errors++;
        $display("FAIL idle_off i=%0d: got b%b l%b s%b a%0d f%b",
                 i, BLANK, LATCH, SCLK, ADDR, frame_start);
      end
      step();
    end
    en = 1'b1;
    step();
    follow_plane(0, 0, 1'b1, 0, 0, 5, -1, -1, -1);
    lat_row   = 0;
    lat_plane = 0;
  endtask

  task automatic test_reset_mid();
    while (!(lat_row == 2 && lat_plane == 0))
      advance(-1, -1, -1);
    advance(-1, -1, 5);
    resetn = 1'b0;
    #1;
    checks++;
    if (BLANK !== 1'b1 || LATCH !== 1'b0 ||
        SCLK !== 1'b0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_ctrl: got b%b l%b s%b f%b",
               BLANK, LATCH, SCLK, frame_start);
    end
    checks++;
    if (RGB0 !== 3'd0 || RGB1 !== 3'd0 ||
        ADDR !== 5'd0 || rd_addr !== 7'd0) begin
      errors++;
      $display("FAIL mid_reset_data: got %h %h %0d %h want 0",
               RGB0, RGB1, ADDR, rd_addr);
    end
    step();
    en     = 1'b1;
    resetn = 1'b1;
    step();
    follow_plane(0, 0, 1'b1, 0, 0, 0, -1, -1, -1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_shift();
    test_bcm();
    test_en_toggle();
    test_wrap();
    test_en_off();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/hub75_scan_ctrl.md
Name: hub75_scan_ctrl

Overview:
Scan sequencer for the 64x64 HUB75 panel, two half-panels driven in parallel. Fetches pixel pairs from the framebuffer and shifts one bit-plane per row into the panel. Generates SCLK, LATCH, BLANK and ADDR with binary-coded modulation (BCM). Sits between the framebuffer RAM and the HUB75 pin mapping in the top level, as the sequencing core of led_main.

Parameters:
COLS, 64, columns per row (shift length)
ROWS, 32, scan rows per half-panel; ADDR width = clog2(ROWS) = 5
BPC, 4, bits per colour channel (BCM planes)
BASE_ON, 8, display cycles for plane 0; plane p is displayed BASE_ON<<p cycles

Ports:
CLK  in  1  system clock (pll_clk domain)
resetn  in  1  asynchronous active-low reset
en  in  1  scan enable
rd_addr  out  clog2(ROWS)+clog2(COLS)  framebuffer address {row, col}
rd_data  in  6*BPC  pixel pair, 1-cycle read latency; [3BPC-1:0] = top pixel {B,G,R}, [6BPC-1:3BPC] = bottom pixel; R in the low BPC bits of each pixel
RGB0  out  3  top-half bits {B,G,R} of the current plane
RGB1  out  3  bottom-half bits {B,G,R} of the current plane
ADDR  out  5  displayed row
BLANK  out  1  1 = panel off
LATCH  out  1  latch pulse
SCLK  out  1  shift clock
frame_start  out  1  1-cycle pulse on latch of row 0, plane 0

Behaviour:
- Clock/reset: one clock CLK; reset is asynchronous and active-low (resetn); all outputs registered.
- Reset values: RGB0=RGB1=0, ADDR=0, BLANK=1, LATCH=0, SCLK=0, rd_addr=0, frame_start=0, state IDLE, row=0, plane=0, timer=0.
- States: IDLE, SHIFT, WAIT, BLK_PRE, LAT, BLK_POST.
- IDLE: BLANK=1. Goes to SHIFT when en=1. Target is row 0, plane 0, timer=0.
- SHIFT, cycle n counted from entry, column slot c occupies cycles 2c and 2c+1:
  - rd_addr={row,c} is visible in cycle 2c.
  - rd_data is sampled at the end of cycle 2c+1.
  - RGB0/RGB1 = bit[plane] of each channel, visible from cycle 2c+2.
  - SCLK=1 in cycle 2c+3 only.
  - SHIFT lasts 2*COLS+2 cycles, giving COLS rising edges with 1 cycle of data setup each.
- WAIT: entered after SHIFT while the display timer is nonzero. Holds until timer==0.
- When the shift is done and timer==0: BLK_PRE, then LAT, then BLK_POST, one cycle each.
  - BLANK=1 in all three.
  - LATCH=1 only in LAT.
  - ADDR takes the just-shifted row in LAT.
- On BLK_POST exit:
  - Timer loads BASE_ON<<latched_plane.
  - The row/plane target advances: plane+1, or on plane==BPC-1, plane=0 and row+1, wrapping at ROWS-1 to 0.
  - State returns to SHIFT, or IDLE if en=0.
- Display: BLANK=0 exactly while timer>0 and state is SHIFT or WAIT. Timer decrements every cycle while >0.
  - BLANK low for exactly BASE_ON<<p cycles per plane, regardless of shift length.
  - Display of plane k overlaps the shift of plane k+1.
- Timer width: clog2(BASE_ON<<(BPC-1))+1.
- frame_start: 1 in the LAT cycle when the latched target is row 0, plane 0.
- en=0 mid-scan: the current shift completes and latches normally. After BLK_POST, go to IDLE with BLANK=1 and the timer cleared (the last plane is not displayed). Re-enable restarts at row 0, plane 0.
- en toggling within one plane has no effect until the latch boundary.
- Reset mid-operation: immediate return to reset values; no partial latch.
- SCLK and LATCH are never high in the same cycle. ADDR changes only while BLANK=1.

Decomposition:
- Shared package/include hub75_pkg:
  - state encoding
  - rd_data field offsets (R/G/B, top/bottom)
  - ADDR and column width constants
  - the BASE_ON<<p on-time function
- One sub-module, hub75_bcm_timer: load value, down-count, busy flag driving BLANK.

Test Plan:
- Reset: assert resetn=0 mid-SHIFT -> next sample BLANK=1, SCLK=0, LATCH=0, ADDR=0, RGB=0; after release with en=1, rd_addr=0 in SHIFT cycle 0.
- Shift pattern, COLS=4, BPC=2, rd_data model returns the low 12 bits of address replicated: exactly 4 SCLK pulses at SHIFT cycles 3,5,7,9; RGB0/RGB1 at each rising edge equal bit[plane] of the model pixel for columns 0..3.
- BCM timing, BASE_ON=16, BPC=2: after the latch of plane 0, BLANK low exactly 16 cycles; after plane 1, exactly 32; WAIT entered when the shift (10 cycles) ends before the timer.
- Latch sequence: BLANK=1 one cycle before LATCH=1, during it, and one cycle after; ADDR updates only in the LATCH cycle; sequence row0/p0, row0/p1, row1/p0.
- Wrap: ROWS=32 run through row 31, plane BPC-1 -> next latch ADDR=0, frame_start=1 for exactly one cycle, once per frame.
- en=0 during SHIFT of row 5 plane 1 -> shift completes, one LATCH with ADDR=5, then IDLE with BLANK=1 steady; en=1 -> first latch is row 0 plane 0 with frame_start=1.
